// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: datapath width, the fetch queue entry
// layout and the canonical NOP used when downstream stages insert bubbles.
package rv_pkg;

    localparam int unsigned XLEN = 32;

    // One prefetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

    // addi x0, x0, 0
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage; the head entry is read straight
// from the storage registers so it carries no combinational path from push.
// Reset clears pointers, occupancy and storage, so the head reads as zero.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;

    // Pointer and occupancy update; pointers wrap because DEPTH is a power of two.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_i) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_i) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and occupancy registers with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (push_i) begin
                mem_q[wptr_q] <= wdata_i;
            end
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: PC generator, synchronous-read imem request port
// and a prefetch queue of {pc, instr} pairs feeding ID through valid/ready.
// A redirect (or reset) flushes the queue and drops the in-flight response.
module fetch_queue #(
    parameter int unsigned     XLEN     = rv_pkg::XLEN,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] PC_INC   = 'd1
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [XLEN-1:0]        imem_addr,
    input  logic [31:0]            imem_rdata,
    input  logic                   redir_valid,
    input  logic [XLEN-1:0]        redir_pc,
    input  logic                   id_ready,
    output logic                   id_valid,
    output logic [31:0]            id_instr,
    output logic [XLEN-1:0]        id_pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;

    logic            fifo_clr;
    logic            push;
    logic            pop;
    logic [XLEN+31:0] head;
    logic [CW-1:0]   occ;
    logic [CW:0]     pending;

    // Outstanding work if we issue now: queued + in flight - leaving this cycle.
    // Issuing only while this stays below DEPTH guarantees every response a slot.
    assign pending  = {1'b0, occ} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};

    assign id_valid = (occ != '0) & ~redir_valid & ~rst;
    assign pop      = id_valid & id_ready;
    assign push     = inflight_q & ~redir_valid & ~rst;
    assign imem_req = ~rst & ~redir_valid & (pending < DEPTH_C);
    assign imem_addr = fpc_q;
    assign fifo_clr = rst | redir_valid;

    sync_fifo #(
        .WIDTH (XLEN + 32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (fifo_clr),
        .push_i  (push),
        .wdata_i ({inflight_pc_q, imem_rdata}),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (occ)
    );

    assign id_instr = head[31:0];
    assign id_pc    = head[XLEN+31:32];
    assign count    = occ;

    // Next fetch PC and in-flight tracking; redirect overrides normal issue.
    always_comb begin
        fpc_d         = fpc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = imem_req;
        if (rst) begin
            fpc_d = RESET_PC;
        end else if (redir_valid) begin
            fpc_d = redir_pc;
        end else if (imem_req) begin
            fpc_d         = fpc_q + PC_INC;
            inflight_pc_d = fpc_q;
        end
    end

    // PC generator and in-flight request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q         <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fpc_q         <= fpc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a queue-based behavioural model of the fetch stage
// checked every cycle, directed scenarios with literal expectations, then a
// long randomized run. A second instance (PC_INC=4, RESET_PC=0x100, DEPTH=2)
// is checked for address stepping and sustained one-per-cycle delivery.
module tb_fetch_queue;
    import rv_pkg::*;

    localparam int DEPTH_A = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A (defaults, DEPTH 4)
    logic        rst, imem_req, redir_valid, id_ready, id_valid;
    logic [31:0] imem_addr, imem_rdata, redir_pc, id_instr, id_pc;
    logic [2:0]  count;

    // Instance B (byte-addressed, DEPTH 2)
    logic        b_rst, b_req, b_valid;
    logic        b_redir = 1'b0;
    logic        b_ready = 1'b1;
    logic [31:0] b_redir_pc = 32'h0;
    logic [31:0] b_addr, b_rdata, b_instr, b_pc;
    logic [1:0]  b_count;

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH_A), .RESET_PC(32'h0), .PC_INC(32'd1)) dut_a (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redir_valid(redir_valid), .redir_pc(redir_pc),
        .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .count(count)
    );

    fetch_queue #(.XLEN(32), .DEPTH(2), .RESET_PC(32'h100), .PC_INC(32'd4)) dut_b (
        .clk(clk), .rst(b_rst), .imem_req(b_req), .imem_addr(b_addr),
        .imem_rdata(b_rdata), .redir_valid(b_redir), .redir_pc(b_redir_pc),
        .id_ready(b_ready), .id_valid(b_valid), .id_instr(b_instr),
        .id_pc(b_pc), .count(b_count)
    );

    int tests = 0;
    int fails = 0;

    // Model state: what the fetch stage holds, in plain terms.
    fetch_entry_t mq[$];
    logic [31:0]  m_fpc;
    bit           m_infl;
    logic [31:0]  m_infl_pc;

    // Per-cycle samples for directed checks
    logic        s_req, s_valid, s_b_req, s_b_valid;
    logic [31:0] s_addr, s_pc, s_instr, s_b_addr, s_b_pc, s_b_instr;
    logic [2:0]  s_count;
    logic [1:0]  s_b_count;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: compare against the model mid-cycle, advance the model
    // at the rising edge, then present the imem responses.
    task automatic cyc();
        bit e_valid, e_pop, e_req;
        fetch_entry_t e;
        @(negedge clk);
        e_valid = !rst && !redir_valid && (mq.size() > 0);
        e_pop   = e_valid && id_ready;
        e_req   = !rst && !redir_valid && (mq.size() + int'(m_infl) - int'(e_pop) < DEPTH_A);

        s_req = imem_req; s_addr = imem_addr; s_valid = id_valid;
        s_pc = id_pc; s_instr = id_instr; s_count = count;
        s_b_req = b_req; s_b_addr = b_addr; s_b_valid = b_valid;
        s_b_pc = b_pc; s_b_instr = b_instr; s_b_count = b_count;

        chk("imem_req", imem_req, e_req);
        if (e_req) chk("imem_addr", imem_addr, m_fpc);
        chk("id_valid", id_valid, e_valid);
        if (e_valid) begin
            chk("id_pc", id_pc, mq[0].pc);
            chk("id_instr", id_instr, mq[0].instr);
        end
        chk("count", count, mq.size());

        @(posedge clk);
        if (rst) begin
            mq.delete(); m_fpc = 32'h0; m_infl = 1'b0;
        end else if (redir_valid) begin
            mq.delete(); m_fpc = redir_pc; m_infl = 1'b0;
        end else begin
            if (e_pop) void'(mq.pop_front());
            if (m_infl) begin
                e.pc = m_infl_pc;
                e.instr = mem_word(m_infl_pc);
                mq.push_back(e);
            end
            if (e_req) begin
                m_infl_pc = m_fpc;
                m_fpc = m_fpc + 32'd1;
            end
            m_infl = e_req;
        end
        #1;
        imem_rdata = m_infl ? mem_word(m_infl_pc) : $urandom;
        b_rdata    = s_b_req ? mem_word(s_b_addr) : 32'hDEAD_BEEF;
    endtask

    initial begin
        int reqs;
        logic [31:0] nxt;

        rst = 1'b1; b_rst = 1'b1; redir_valid = 1'b0; redir_pc = 32'h0;
        id_ready = 1'b1; imem_rdata = 32'h0; b_rdata = 32'h0;
        @(posedge clk);
        #1;
        mq.delete(); m_fpc = 32'h0; m_infl = 1'b0; m_infl_pc = 32'h0;

        // Reset values
        cyc(); cyc();
        chk("rst_imem_req", s_req, 0);
        chk("rst_id_valid", s_valid, 0);
        chk("rst_count", s_count, 0);
        chk("rst_id_pc", s_pc, 0);
        chk("rst_id_instr", s_instr, 0);
        chk("rst_b_req", s_b_req, 0);

        // Free run with id_ready high; instance B runs alongside
        rst = 1'b0; b_rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk("free_addr", s_addr, k);
            chk("free_count_le1", s_count <= 1, 1);
            if (k < 2) chk("free_valid_early", s_valid, 0);
            else begin
                chk("free_valid", s_valid, 1);
                chk("free_pc", s_pc, k - 2);
            end
            chk("b_req", s_b_req, 1);
            chk("b_addr", s_b_addr, 32'h100 + 4 * k);
            chk("b_count_le1", s_b_count <= 1, 1);
            if (k < 2) chk("b_valid_early", s_b_valid, 0);
            else begin
                chk("b_valid", s_b_valid, 1);
                chk("b_pc", s_b_pc, 32'h100 + 4 * (k - 2));
                chk("b_instr", s_b_instr, mem_word(32'h100 + 4 * (k - 2)));
            end
        end

        // Stall from cycle 0: exactly DEPTH requests, then drain in order
        rst = 1'b1; cyc(); rst = 1'b0; id_ready = 1'b0;
        reqs = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (s_req) begin
                chk("stall_addr", s_addr, reqs);
                reqs++;
            end
        end
        chk("stall_reqs", reqs, 4);
        chk("stall_count", s_count, 4);
        chk("stall_req_off", s_req, 0);
        id_ready = 1'b1;
        nxt = 32'h0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            if (s_valid) begin
                chk("drain_order", s_pc, nxt);
                nxt = nxt + 32'd1;
            end
        end
        chk("drain_total", nxt, 12);

        // Redirect with 3 queued entries and one in flight
        rst = 1'b1; cyc(); rst = 1'b0; id_ready = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        redir_valid = 1'b1; redir_pc = 32'h40;
        cyc();
        chk("redir_count_R", s_count, 3);
        chk("redir_valid_R", s_valid, 0);
        chk("redir_req_R", s_req, 0);
        redir_valid = 1'b0; id_ready = 1'b1;
        cyc();
        chk("redir_count_R1", s_count, 0);
        chk("redir_req_R1", s_req, 1);
        chk("redir_addr_R1", s_addr, 32'h40);
        cyc();
        chk("redir_valid_R2", s_valid, 0);
        cyc();
        chk("redir_valid_R3", s_valid, 1);
        chk("redir_pc_R3", s_pc, 32'h40);

        // Redirect coinciding with a full queue and id_ready high
        rst = 1'b1; cyc(); rst = 1'b0; id_ready = 1'b0;
        for (int k = 0; k < 6; k++) cyc();
        chk("full_count", s_count, 4);
        id_ready = 1'b1; redir_valid = 1'b1; redir_pc = 32'h80;
        cyc();
        chk("full_redir_valid", s_valid, 0);
        redir_valid = 1'b0;
        cyc();
        chk("full_redir_count", s_count, 0);
        cyc(); cyc();
        chk("full_redir_valid_R3", s_valid, 1);
        chk("full_redir_pc", s_pc, 32'h80);

        // Reset mid-stream with 2 entries queued
        rst = 1'b1; cyc(); rst = 1'b0; id_ready = 1'b0;
        for (int k = 0; k < 3; k++) cyc();
        chk("midrst_pre_count", s_count, 1);
        rst = 1'b1; cyc(); cyc();
        chk("midrst_req", s_req, 0);
        chk("midrst_valid", s_valid, 0);
        chk("midrst_count", s_count, 0);
        chk("midrst_pc", s_pc, 0);
        rst = 1'b0; id_ready = 1'b1;
        cyc();
        chk("midrst_first_addr", s_addr, 0);
        chk("midrst_first_req", s_req, 1);

        // Randomized traffic, including redirects near the top of the address space
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(99) == 0);
            redir_valid = ($urandom_range(19) == 0);
            redir_pc = ($urandom_range(1) == 0) ? $urandom : (32'hFFFF_FFFC + $urandom_range(3));
            id_ready = ($urandom_range(9) < 7);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
